// File: rtl/mode_arb_pkg.sv
// Shared types and default parameters for the mode/subtype request arbiter.
// Optional strict-priority build switch: MODE_ARB_PRIO_EN.
package mode_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  typedef logic [2:0] mode_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/mode_arb_rr_pick.sv
// Combinational round-robin pick: first set request strictly after ptr_i, with wrap.
// Rotates the request vector so the search always starts at bit 0, then priority-encodes.
module mode_arb_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [2*N-1:0] req2_s;
  logic [IDX_W:0] shift_s;
  logic [N-1:0]   rot_s;

  // Map a rotated position back to a requester index (sum never reaches 2*N).
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] base, input int unsigned off);
    logic [IDX_W:0] sum;
    sum = base + (IDX_W+1)'(off);
    sum = (sum >= (IDX_W+1)'(N)) ? (sum - (IDX_W+1)'(N)) : sum;
    return IDX_W'(sum);
  endfunction

  assign req2_s  = {req_i, req_i};
  assign shift_s = {1'b0, ptr_i} + (IDX_W+1)'(1);
  assign rot_s   = N'(req2_s >> shift_s);

  // Lowest set rotated bit wins; scan downward so the last hit is the lowest.
  always_comb begin
    idx_o   = '0;
    found_o = |rot_s;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = rot_s[i] ? wrap_idx(shift_s, i) : idx_o;
    end
  end

endmodule

// File: rtl/mode_req_arbiter.sv
// Round-robin arbiter sharing one mode/subtype datapath among NUM_REQ burst requesters.
// Build switch MODE_ARB_PRIO_EN: requester 0 gets strict priority over the round-robin group.
module mode_req_arbiter
  import mode_arb_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  mode_t [NUM_REQ-1:0]            req_mode,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output mode_t                          out_mode,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_last,
  output logic [IDX_W-1:0]               out_src,
  output logic                           busy
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] pick_req_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_found_s;
  logic             accept_s;

`ifdef MODE_ARB_PRIO_EN
  assign pick_req_s = {req_valid[NUM_REQ-1:1], 1'b0};
`else
  assign pick_req_s = req_valid;
`endif

  mode_arb_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (pick_req_s),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // State, pointer, grant index and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      gnt_idx_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Arbitration, zero-latency forwarding and release decision.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    beat_cnt_d = beat_cnt_q;
    out_valid  = 1'b0;
    out_mode   = 3'b000;
    out_data   = '0;
    out_last   = 1'b0;
    req_ready  = '0;
    accept_s   = 1'b0;
    busy       = (state_q == ARB_GRANT);
    out_src    = gnt_idx_q;

    case (state_q)
      ARB_IDLE: begin
        beat_cnt_d = '0;
`ifdef MODE_ARB_PRIO_EN
        if (req_valid[0]) begin
          gnt_idx_d = '0;
          state_d   = ARB_GRANT;
        end else if (pick_found_s) begin
          gnt_idx_d = pick_idx_s;
          state_d   = ARB_GRANT;
        end else begin
          state_d   = ARB_IDLE;
        end
`else
        if (pick_found_s) begin
          gnt_idx_d = pick_idx_s;
          state_d   = ARB_GRANT;
        end else begin
          state_d   = ARB_IDLE;
        end
`endif
      end

      ARB_GRANT: begin
        out_valid            = req_valid[gnt_idx_q];
        out_mode             = req_mode[gnt_idx_q];
        out_data             = req_data[gnt_idx_q];
        out_last             = req_last[gnt_idx_q] || (beat_cnt_q == BCW'(MAX_BURST - 1));
        req_ready[gnt_idx_q] = out_ready;
        accept_s             = out_valid && out_ready;
        if (accept_s && out_last) begin
          state_d    = ARB_IDLE;
          beat_cnt_d = '0;
`ifdef MODE_ARB_PRIO_EN
          // Requester 0 grants leave the round-robin position untouched.
          rr_ptr_d   = (gnt_idx_q != '0) ? gnt_idx_q : rr_ptr_q;
`else
          rr_ptr_d   = gnt_idx_q;
`endif
        end else if (accept_s) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end else begin
          state_d    = ARB_GRANT;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule
